debug_dump_tx: RTL

- Transmit side of the MIPS debug unit.
- After the processor halts, it serializes the machine state into the UART transmitter as a fixed 260-byte stream:
  - the PC,
  - then registers 0..31,
  - then data-memory words 0..31.
- Each 32-bit word is sent least-significant byte first.
- It sits between the pipeline's debug read ports and the UART TX handshake. It is the counterpart of the host-side receiver that reassembles PC, register and memory words.

---
 rtl/debug_dump_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - streams PC, register file and data memory to the UART TX after a halt
// Word order: PC, regs 0..NUM_REGS-1, mem 0..NUM_MEM-1; each word LSB first.
module debug_dump_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int NUM_REGS        = 32,
  parameter int NUM_MEM         = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [4:0]                 o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_tx_signal,
  input  logic                       i_tx_available,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int         BYTES     = DATA_WIDTH / DATA_WIDTH_UART;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);
  localparam logic [6:0] LAST_REG  = 7'(NUM_REGS);
  localparam logic [6:0] FIRST_MEM = 7'(NUM_REGS + 1);
  localparam logic [6:0] LAST_IDX  = 7'(NUM_REGS + NUM_MEM);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_SEND, ST_WAIT, ST_DONE
  } state_t;

  state_t                state, state_next;
  logic [6:0]            idx, idx_next;
  logic [1:0]            bcnt, bcnt_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [4:0]            reg_addr_next, mem_addr_next;
  logic                  reg_sel_next, mem_sel_next, reg_sel, mem_sel;

  assign reg_addr_next = 5'(idx_next - 7'd1);
  assign mem_addr_next = 5'(idx_next - FIRST_MEM);
  assign reg_sel_next  = (idx_next != 7'd0) && (idx_next <= LAST_REG);
  assign mem_sel_next  = (idx_next >= FIRST_MEM);
  assign reg_sel       = (idx != 7'd0) && (idx <= LAST_REG);
  assign mem_sel       = (idx >= FIRST_MEM);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    bcnt_next  = bcnt;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          idx_next   = 7'd0;
          bcnt_next  = 2'd0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: state_next = ST_SEND;
      ST_SEND: begin
        if (i_tx_available) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (bcnt != LAST_BYTE) begin
            bcnt_next  = bcnt + 2'd1;
            state_next = ST_SEND;
          end else if (idx != LAST_IDX) begin
            idx_next   = idx + 7'd1;
            bcnt_next  = 2'd0;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Addresses are set on entry to FETCH so synchronous read data is ready in LATCH.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      idx        <= 7'd0;
      bcnt       <= 2'd0;
      shift      <= '0;
      o_reg_addr <= 5'd0;
      o_mem_addr <= 5'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      bcnt  <= bcnt_next;
      if (state == ST_LATCH) begin
        if (mem_sel)      shift <= i_mem_data;
        else if (reg_sel) shift <= i_reg_data;
        else              shift <= i_pc;
      end else if (state == ST_WAIT && i_tx_done && bcnt != LAST_BYTE) begin
        shift <= shift >> DATA_WIDTH_UART;
      end
      if (state_next == ST_FETCH) begin
        if (reg_sel_next)      o_reg_addr <= reg_addr_next;
        else if (mem_sel_next) o_mem_addr <= mem_addr_next;
      end
    end
  end

  assign o_tx_byte   = shift[DATA_WIDTH_UART-1:0];
  assign o_tx_signal = (state == ST_SEND) && i_tx_available;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);

endmodule
